// File: rtl/ptype.sv
// Shared types for the 16-bit compute unit and its sequencer.
// The WAIT state exists only when CU_SEQ_PIPE_EN is defined.
package ptype;

    localparam int CU_SEQ_DW = 16;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR
    } operation_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

`ifdef CU_SEQ_PIPE_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP,
        S_WAIT
    } cu_seq_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } cu_seq_state_t;
`endif

endpackage

// File: rtl/cu_sequencer_if.sv
// Command, load, compute-unit and response signals of cu_sequencer.
// master is the sequencer side, slave is its environment.
interface cu_sequencer_if #(
    parameter int NREGS = 8
);
    import ptype::*;

    localparam int AW = $clog2(NREGS);

    logic                 cmd_valid;
    logic                 cmd_ready;
    operation_t           cmd_op;
    logic [AW-1:0]        cmd_rs1;
    logic [AW-1:0]        cmd_rs2;
    logic [AW-1:0]        cmd_rd;
    logic                 cmd_wb;

    logic                 ld_en;
    logic [AW-1:0]        ld_addr;
    logic [CU_SEQ_DW-1:0] ld_data;

    logic [CU_SEQ_DW-1:0] op1;
    logic [CU_SEQ_DW-1:0] op2;
    operation_t           op;
    logic [CU_SEQ_DW-1:0] result;
    flags_t               fls;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CU_SEQ_DW-1:0] rsp_result;
    flags_t               rsp_fls;
    logic [AW-1:0]        rsp_rd;

    modport master (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wb,
        input  ld_en, ld_addr, ld_data,
        input  result, fls,
        input  rsp_ready,
        output cmd_ready,
        output op1, op2, op,
        output rsp_valid, rsp_result, rsp_fls, rsp_rd
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wb,
        output ld_en, ld_addr, ld_data,
        output result, fls,
        output rsp_ready,
        input  cmd_ready,
        input  op1, op2, op,
        input  rsp_valid, rsp_result, rsp_fls, rsp_rd
    );

endinterface

// File: rtl/cu_seq_rf.sv
// Operand register file: two async read ports, load and write-back
// write ports (write-back wins on the same address), sync clear.
module cu_seq_rf #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic [DW-1:0] mem [NREGS];

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                mem[ld_addr] <= ld_data;
            end
            // later assignment takes priority on an address collision
            if (wb_en) begin
                mem[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// One-command-in-flight controller for the 16-bit compute unit.
// CU_SEQ_PIPE_EN registers result/fls and adds a WAIT state.
module cu_sequencer
    import ptype::*;
#(
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input logic      clk,
    input logic      rst,
    cu_sequencer_if.master bus
);

    cu_seq_state_t        state;
    logic [CU_SEQ_DW-1:0] opa;
    logic [CU_SEQ_DW-1:0] opb;
    operation_t           opq;
    logic [AW-1:0]        rdq;
    logic                 wbq;
    logic                 issued;

    logic                 rdy;
    logic [CU_SEQ_DW-1:0] op1_r;
    logic [CU_SEQ_DW-1:0] op2_r;
    operation_t           op_r;
    logic                 rsp_v;
    logic [CU_SEQ_DW-1:0] rsp_res;
    flags_t               rsp_f;
    logic [AW-1:0]        rsp_rd_r;

    logic [CU_SEQ_DW-1:0] rd1;
    logic [CU_SEQ_DW-1:0] rd2;
    logic                 wb_en;
    logic [CU_SEQ_DW-1:0] wb_data;

`ifdef CU_SEQ_PIPE_EN
    logic [CU_SEQ_DW-1:0] res_q;
    flags_t               fls_q;

    assign wb_en   = (state == S_WAIT) && wbq;
    assign wb_data = res_q;
`else
    assign wb_en   = (state == S_EXEC) && issued && wbq;
    assign wb_data = bus.result;
`endif

    cu_seq_rf #(
        .NREGS (NREGS),
        .DW    (CU_SEQ_DW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra1     (bus.cmd_rs1),
        .ra2     (bus.cmd_rs2),
        .rd1     (rd1),
        .rd2     (rd2),
        .ld_en   (bus.ld_en),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data),
        .wb_en   (wb_en),
        .wb_addr (rdq),
        .wb_data (wb_data)
    );

    assign bus.cmd_ready  = rdy;
    assign bus.op1        = op1_r;
    assign bus.op2        = op2_r;
    assign bus.op         = op_r;
    assign bus.rsp_valid  = rsp_v;
    assign bus.rsp_result = rsp_res;
    assign bus.rsp_fls    = rsp_f;
    assign bus.rsp_rd     = rsp_rd_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            opa      <= '0;
            opb      <= '0;
            opq      <= OP_ADD;
            rdq      <= '0;
            wbq      <= 1'b0;
            issued   <= 1'b0;
            rdy      <= 1'b1;
            op1_r    <= '0;
            op2_r    <= '0;
            op_r     <= OP_ADD;
            rsp_v    <= 1'b0;
            rsp_res  <= '0;
            rsp_f    <= '0;
            rsp_rd_r <= '0;
`ifdef CU_SEQ_PIPE_EN
            res_q    <= '0;
            fls_q    <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && rdy) begin
                        opa    <= rd1;
                        opb    <= rd2;
                        opq    <= bus.cmd_op;
                        rdq    <= bus.cmd_rd;
                        wbq    <= bus.cmd_wb;
                        issued <= 1'b0;
                        rdy    <= 1'b0;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // first cycle presents operands, second samples the unit
                    if (!issued) begin
                        op1_r  <= opa;
                        op2_r  <= opb;
                        op_r   <= opq;
                        issued <= 1'b1;
                    end else begin
`ifdef CU_SEQ_PIPE_EN
                        res_q <= bus.result;
                        fls_q <= bus.fls;
                        state <= S_WAIT;
`else
                        rsp_res  <= bus.result;
                        rsp_f    <= bus.fls;
                        rsp_rd_r <= rdq;
                        rsp_v    <= 1'b1;
                        state    <= S_RESP;
`endif
                    end
                end
`ifdef CU_SEQ_PIPE_EN
                S_WAIT: begin
                    rsp_res  <= res_q;
                    rsp_f    <= fls_q;
                    rsp_rd_r <= rdq;
                    rsp_v    <= 1'b1;
                    state    <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_v <= 1'b0;
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b1;
                    rsp_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer with a behavioural compute unit.
module tb_cu_sequencer;
    import ptype::*;

`ifdef CU_SEQ_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    cu_sequencer_if #(.NREGS(8)) bus();

    cu_sequencer #(.NREGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] wide;
    always_comb begin
        wide = '0;
        case (bus.op)
            OP_ADD:  wide = {1'b0, bus.op1} + {1'b0, bus.op2};
            OP_SUB:  wide = {1'b0, bus.op1} - {1'b0, bus.op2};
            OP_MUL:  wide = {1'b0, 16'(bus.op1 * bus.op2)};
            OP_AND:  wide = {1'b0, bus.op1 & bus.op2};
            default: wide = {1'b0, bus.op1 ^ bus.op2};
        endcase
    end
    assign bus.result = wide[15:0];
    assign bus.fls    = '{z: (wide[15:0] == 16'h0), n: wide[15],
                          c: wide[16], v: 1'b0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ld(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 3'(a);
        bus.ld_data = d;
        @(negedge clk);
        bus.ld_en   = 1'b0;
    endtask

    task automatic run_cmd(input operation_t o, input int r1, input int r2,
                           input int rd, input bit wb,
                           input logic [15:0] e, input int hold,
                           input bit coll, input logic [15:0] cdata);
        exp_t        x;
        int          n;
        bit          acc;
        logic [15:0] held;
        x.res = e;
        x.rd  = 3'(rd);
        sb.push_back(x);
        @(negedge clk);
        bus.cmd_op    = o;
        bus.cmd_rs1   = 3'(r1);
        bus.cmd_rs2   = 3'(r2);
        bus.cmd_rd    = 3'(rd);
        bus.cmd_wb    = wb;
        bus.cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", {31'b0, acc}, 32'd1);
        if (!acc) begin
            bus.cmd_valid = 1'b0;
            x = sb.pop_back();
            return;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (coll && i == LAT - 1) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = 3'(rd);
                bus.ld_data = cdata;
            end
            if (coll && i == LAT) bus.ld_en = 1'b0;
            if (bus.rsp_valid) begin
                n = i;
                break;
            end
        end
        chk("latency", 32'(n), 32'(LAT));
        if (n == 0) begin
            x = sb.pop_back();
            return;
        end
        held = bus.rsp_result;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_rd    = 3'd5;
            @(posedge clk);
            #1;
            chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_ready", {31'b0, bus.cmd_ready}, 32'd0);
            chk("bp_hold", {16'b0, bus.rsp_result}, {16'b0, held});
        end
        bus.cmd_valid = 1'b0;
        x = sb.pop_front();
        chk("result", {16'b0, bus.rsp_result}, {16'b0, x.res});
        chk("rd", {29'b0, bus.rsp_rd}, {29'b0, x.rd});
        chk("flags", {28'b0, bus.rsp_fls},
            {28'b0, (x.res == 16'h0), x.res[15], 2'b00});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("idle_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_rd    = '0;
        bus.cmd_wb    = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_result", {16'b0, bus.rsp_result}, 32'd0);
        chk("rst_fls", {28'b0, bus.rsp_fls}, 32'd0);
        chk("rst_rd", {29'b0, bus.rsp_rd}, 32'd0);
        chk("rst_op1", {16'b0, bus.op1}, 32'd0);
        chk("rst_op", {29'b0, bus.op}, {29'b0, OP_ADD});

        ld(1, 16'd3);
        ld(2, 16'd5);
        run_cmd(OP_ADD, 1, 2, 3, 1'b1, 16'd8, 0, 1'b0, 16'h0);
        run_cmd(OP_ADD, 3, 0, 5, 1'b0, 16'd8, 0, 1'b0, 16'h0);
        chk("op_hold", {16'b0, bus.op1}, 32'd8);

        ld(1, 16'd300);
        ld(2, 16'd300);
        run_cmd(OP_MUL, 1, 2, 6, 1'b0, 16'h5F90, 0, 1'b0, 16'h0);
        run_cmd(OP_ADD, 1, 2, 7, 1'b1, 16'd600, 5, 1'b0, 16'h0);
        run_cmd(OP_ADD, 7, 0, 2, 1'b0, 16'd600, 0, 1'b0, 16'h0);

        ld(1, 16'd3);
        ld(2, 16'd5);
        run_cmd(OP_ADD, 1, 2, 3, 1'b1, 16'd8, 0, 1'b1, 16'hAAAA);
        run_cmd(OP_ADD, 3, 0, 0, 1'b0, 16'd8, 0, 1'b0, 16'h0);

        @(negedge clk);
        bus.cmd_op    = OP_ADD;
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd2;
        bus.cmd_rd    = 3'd4;
        bus.cmd_wb    = 1'b1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
            chk("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        end
        run_cmd(OP_ADD, 4, 0, 4, 1'b0, 16'd0, 0, 1'b0, 16'h0);

        ld(1, 16'd10);
        ld(2, 16'd3);
        run_cmd(OP_SUB, 1, 2, 5, 1'b0, 16'd7, 0, 1'b0, 16'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Initiator-side controller for the 16-bit compute unit. It accepts register-addressed commands over a valid/ready handshake and reads operands from an internal register file. It drives the compute unit's `op1`/`op2`/`op` inputs, captures `result`/`fls`, optionally writes the result back, and returns a response over a second valid/ready handshake. It sits between the instruction/command source and the combinational compute unit.

## Interface

Parameters:
- `NREGS`, 8: number of 16-bit registers in the file.
- `AW`, `$clog2(NREGS)`: register address width; derived, not overridden.

Ports. Clock is `clk`; reset is `rst`, synchronous and active-high; one clock domain.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in `operation_t`: operation to issue.
- `cmd_rs1` in AW: source register for `op1`.
- `cmd_rs2` in AW: source register for `op2`.
- `cmd_rd` in AW: destination register.
- `cmd_wb` in 1: write the result back to `cmd_rd`.
- `ld_en` in 1: direct register load strobe.
- `ld_addr` in AW: load address.
- `ld_data` in 16: load data.
- `op1` out 16: compute unit operand 1.
- `op2` out 16: compute unit operand 2.
- `op` out `operation_t`: compute unit operation.
- `result` in 16: compute unit result.
- `fls` in `flags_t`: compute unit flags.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 16: captured result.
- `rsp_fls` out `flags_t`: captured flags.
- `rsp_rd` out AW: destination register of the command.

## Operation

- FSM states: IDLE, EXEC, RESP; WAIT is added only under the macro.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`, latch `cmd_op`, `cmd_rd`, `cmd_wb`.
  - Latch `rf[cmd_rs1]` and `rf[cmd_rs2]` into the operand registers, then go to EXEC.
- EXEC:
  - `op1`/`op2`/`op` are driven from the operand registers.
  - Capture `result`/`fls` into the `rsp_*` registers.
  - If `wb`, write `rf[rd]`=`result`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. Exactly one command is in flight.
- `op1`/`op2`/`op` hold their last issued values outside EXEC.
- Load port:
  - `ld_en` writes `rf[ld_addr]` in any state.
  - If a write-back targets the same address in the same cycle, the write-back wins.
- Operand reads are read-before-write: a load or write-back landing in the accept cycle is not seen by that command.
- MUL returns the low 16 bits, as produced by the compute unit; the sequencer performs no arithmetic.

## Timing

- Reset values:
  - `cmd_ready`=1 from the first cycle after `rst` deasserts; state IDLE.
  - `rsp_valid`=0.
  - `rsp_result`=0, `rsp_fls`=0, `rsp_rd`=0.
  - `op1`=`op2`=0, `op`=the first enumerator of `operation_t`.
  - All registers in the file = 0.
- Latency: command accepted at edge T, `rsp_valid` rises after edge T+2. The next command can be accepted in the cycle after response acceptance.
- A write-back is visible to a command accepted on the same edge as the response handshake.
- `rst` asserted in any state: the in-flight command is dropped, no write-back occurs, and `rsp_valid` drops the next cycle.
- `cmd_valid` may drop before acceptance without error. Payload is sampled only at the handshake.

## Configuration

- `CU_SEQ_PIPE_EN` defined:
  - `result`/`fls` are registered at the end of EXEC.
  - WAIT captures from those registers and performs the write-back, then goes to RESP.
  - Latency becomes T+3.
- Not defined: no WAIT state; latency T+2.

## Structure

- `operation_t` and `flags_t` come from the shared `ptype` package. Add the state enum `cu_seq_state_t` and `CU_SEQ_DW=16` there.
- Sub-module `cu_seq_rf`: NREGS×16 register file with two read ports and two write ports (load and write-back), write-back priority, and synchronous reset clear.
- The compute unit is instantiated outside the sequencer by the parent.

## Test plan

- Reset: hold `rst` 2 cycles, then release -> `cmd_ready`=1, `rsp_valid`=0, and every `rsp_*` output is 0.
- Basic issue: ld r1=3, ld r2=5, then ADD rs1=1 rs2=2 rd=3 wb=1 -> `rsp_valid` at T+2, `rsp_result`=8, `rsp_rd`=3. A follow-up ADD r3,r0 returns 8.
- Multiply: ld r1=300, ld r2=300, then MUL -> `rsp_result`=0x5F90. Check at T+3 with `CU_SEQ_PIPE_EN`.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` stays 1, `rsp_*` stable, `cmd_ready`=0. A new `cmd_valid` is ignored until the response is accepted.
- Write collision: `ld_en` to r3 with 0xAAAA in the same cycle as a write-back of 8 to r3 -> r3 reads 8.
- Reset mid-operation: assert `rst` during EXEC of ADD rd=4 wb=1 -> no `rsp_valid`, r4 stays 0, `cmd_ready`=1 after release.
